my9262_frame_sched: RTL and testbench

Frame scheduler for a daisy chain of MY9262 LED drivers. Per frame it reads grayscale words from the frame buffer in chain order and issues them one word at a time to the serial word shifter, tagging each word with the latch action the shifter must generate. On a pending configuration request it first sends one configuration word per chip. It sits between the frame-buffer/host logic and the existing MY9262 serial shifter (DCLK/DI/LAT).

---
 rtl/my9262_pkg.sv | 34 +++
 rtl/my9262_chain_addr_gen.sv | 73 +++++++
 rtl/my9262_frame_sched.sv | 195 +++++++++++++++++++
 tb/tb_my9262_frame_sched.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/my9262_pkg.sv
// MY9262 chain scheduling shared types: shifter word kinds,
// scheduler state encoding and small sizing helpers.
package my9262_pkg;

   localparam logic [1:0] KIND_SHIFT = 2'd0;
   localparam logic [1:0] KIND_DLAT  = 2'd1;
   localparam logic [1:0] KIND_GLAT  = 2'd2;
   localparam logic [1:0] KIND_CLAT  = 2'd3;

   localparam int CHIP_W = 6;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CFG,
      ST_FETCH,
      ST_RD,
      ST_SEND,
      ST_GLAT,
      ST_DONE
   } sched_st_t;

   typedef enum logic [2:0] {
      AG_HOLD,
      AG_LOAD,
      AG_DEC,
      AG_NEXT_CH,
      AG_CLR
   } ag_op_t;

   function automatic int ch_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/my9262_chain_addr_gen.sv
// Channel/chip walker for the MY9262 chain. Ports: CLK_200M, RST_N,
// i_op (counter command), o_addr (base+chip), o_last_chip, o_last_ch,
// o_pat (walking channel/chip word, only with MY9262_SCHED_TESTPAT_EN).
import my9262_pkg::*;

module my9262_chain_addr_gen #(
   parameter int NUM_CHIPS   = 10,
   parameter int CH_PER_CHIP = 16,
   parameter int ADDR_W      = 10
) (
   input  logic              CLK_200M,
   input  logic              RST_N,
   input  ag_op_t            i_op,
   output logic [ADDR_W-1:0] o_addr,
   output logic              o_last_chip,
`ifdef MY9262_SCHED_TESTPAT_EN
   output logic [15:0]       o_pat,
`endif
   output logic              o_last_ch
);

   localparam int CH_W = ch_width(CH_PER_CHIP);
   localparam logic [CHIP_W-1:0] CHIP_MAX = CHIP_W'(NUM_CHIPS - 1);
   localparam logic [CH_W-1:0]   CH_MAX   = CH_W'(CH_PER_CHIP - 1);
   localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(NUM_CHIPS);

   logic [CHIP_W-1:0] r_chip;
   logic [CH_W-1:0]   r_ch;
   logic [ADDR_W-1:0] r_base;

   // r_base tracks ch*NUM_CHIPS so no multiplier is needed
   always_ff @(posedge CLK_200M or negedge RST_N) begin
      if (!RST_N) begin
         r_chip <= '0;
         r_ch   <= '0;
         r_base <= '0;
      end else begin
         unique case (i_op)
            AG_LOAD: begin
               r_chip <= CHIP_MAX;
               r_ch   <= '0;
               r_base <= '0;
            end
            AG_DEC: begin
               r_chip <= r_chip - 1'b1;
            end
            AG_NEXT_CH: begin
               r_chip <= CHIP_MAX;
               r_ch   <= r_ch + 1'b1;
               r_base <= r_base + STEP;
            end
            AG_CLR: begin
               r_chip <= '0;
               r_ch   <= '0;
               r_base <= '0;
            end
            default: begin
            end
         endcase
      end
   end

   assign o_addr      = r_base + ADDR_W'(r_chip);
   assign o_last_chip = (r_chip == '0);
   assign o_last_ch   = (r_ch == CH_MAX);

`ifdef MY9262_SCHED_TESTPAT_EN
   logic [3:0] w_ch4;
   assign w_ch4 = 4'(r_ch);
   assign o_pat = {w_ch4, 2'b00, r_chip, 4'h0};
`endif

endmodule

// File: rtl/my9262_frame_sched.sv
// MY9262 frame scheduler: config words, then grayscale words in chain order,
// then a global latch word, each offered to the serial shifter with its kind.
// Ports: CLK_200M/RST_N; frame_start, cfg_req, cfg_word (host side);
// fb_rd_en/fb_rd_addr/fb_rd_data (frame buffer, 1-cycle read latency);
// sh_valid/sh_ready/sh_data/sh_kind (shifter); busy, frame_done (status).
// Build option: MY9262_SCHED_TESTPAT_EN replaces buffer reads with a
// walking {ch, 2'b00, chip, 4'h0} pattern and keeps fb_rd_en low.
import my9262_pkg::*;

module my9262_frame_sched #(
   parameter int NUM_CHIPS   = 10,
   parameter int CH_PER_CHIP = 16,
   parameter int ADDR_W      = 10
) (
   input  logic              CLK_200M,
   input  logic              RST_N,
   input  logic              frame_start,
   input  logic              cfg_req,
   input  logic [15:0]       cfg_word,
   output logic              fb_rd_en,
   output logic [ADDR_W-1:0] fb_rd_addr,
   input  logic [15:0]       fb_rd_data,
   output logic              sh_valid,
   input  logic              sh_ready,
   output logic [15:0]       sh_data,
   output logic [1:0]        sh_kind,
   output logic              busy,
   output logic              frame_done
);

   sched_st_t   r_state;
   logic        r_frame_pend;
   logic        r_cfg_pend;
   logic        r_fb_rd_en;
   logic        r_sh_valid;
   logic [15:0] r_sh_data;
   logic [1:0]  r_sh_kind;
   logic        r_busy;
   logic        r_frame_done;

   ag_op_t      w_op;
   logic        w_last_chip;
   logic        w_last_ch;
   logic        w_xfer;
   logic        w_go;
   logic        w_do_cfg;
   logic [15:0] w_rd_word;

`ifdef MY9262_SCHED_TESTPAT_EN
   localparam logic RD_EN = 1'b0;
   logic [15:0] w_pat;
   logic        w_unused_rd;
   assign w_unused_rd = ^fb_rd_data;
   assign w_rd_word   = w_pat;
`else
   localparam logic RD_EN = 1'b1;
   assign w_rd_word = fb_rd_data;
`endif

   my9262_chain_addr_gen #(
      .NUM_CHIPS   (NUM_CHIPS),
      .CH_PER_CHIP (CH_PER_CHIP),
      .ADDR_W      (ADDR_W)
   ) u_addr (
      .CLK_200M    (CLK_200M),
      .RST_N       (RST_N),
      .i_op        (w_op),
      .o_addr      (fb_rd_addr),
      .o_last_chip (w_last_chip),
`ifdef MY9262_SCHED_TESTPAT_EN
      .o_pat       (w_pat),
`endif
      .o_last_ch   (w_last_ch)
   );

   assign w_xfer   = r_sh_valid & sh_ready;
   assign w_go     = r_frame_pend | frame_start;
   assign w_do_cfg = r_cfg_pend | cfg_req;

   always_comb begin
      w_op = AG_HOLD;
      unique case (r_state)
         ST_IDLE:
            if (w_go) w_op = AG_LOAD;
         ST_CFG:
            if (w_xfer) w_op = w_last_chip ? AG_LOAD : AG_DEC;
         ST_SEND:
            if (w_xfer) begin
               if (!w_last_chip)    w_op = AG_DEC;
               else if (!w_last_ch) w_op = AG_NEXT_CH;
            end
         ST_DONE:
            w_op = AG_CLR;
         default: w_op = AG_HOLD;
      endcase
   end

   always_ff @(posedge CLK_200M or negedge RST_N) begin
      if (!RST_N) begin
         r_state      <= ST_IDLE;
         r_frame_pend <= 1'b0;
         r_cfg_pend   <= 1'b1;
         r_fb_rd_en   <= 1'b0;
         r_sh_valid   <= 1'b0;
         r_sh_data    <= '0;
         r_sh_kind    <= KIND_SHIFT;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         // a start seen in IDLE is consumed on the spot
         if (r_state == ST_IDLE && w_go)
            r_frame_pend <= 1'b0;
         else if (frame_start)
            r_frame_pend <= 1'b1;

         // a cfg_req racing the last config word still counts
         if (cfg_req)
            r_cfg_pend <= 1'b1;
         else if (r_state == ST_CFG && w_xfer && w_last_chip)
            r_cfg_pend <= 1'b0;

         unique case (r_state)
            ST_IDLE: begin
               if (w_go) begin
                  r_busy <= 1'b1;
                  if (w_do_cfg) begin
                     r_state <= ST_CFG;
                  end else begin
                     r_state    <= ST_FETCH;
                     r_fb_rd_en <= RD_EN;
                  end
               end
            end
            ST_CFG: begin
               if (!r_sh_valid) begin
                  r_sh_data  <= cfg_word;
                  r_sh_kind  <= w_last_chip ? KIND_CLAT : KIND_SHIFT;
                  r_sh_valid <= 1'b1;
               end else if (sh_ready) begin
                  r_sh_valid <= 1'b0;
                  if (w_last_chip) begin
                     r_state    <= ST_FETCH;
                     r_fb_rd_en <= RD_EN;
                  end
               end
            end
            ST_FETCH: begin
               r_fb_rd_en <= 1'b0;
               r_state    <= ST_RD;
            end
            ST_RD: begin
               r_sh_data  <= w_rd_word;
               r_sh_kind  <= w_last_chip ? KIND_DLAT : KIND_SHIFT;
               r_sh_valid <= 1'b1;
               r_state    <= ST_SEND;
            end
            ST_SEND: begin
               if (w_xfer) begin
                  if (!w_last_chip || !w_last_ch) begin
                     r_sh_valid <= 1'b0;
                     r_fb_rd_en <= RD_EN;
                     r_state    <= ST_FETCH;
                  end else begin
                     // global latch word follows back-to-back
                     r_sh_data <= '0;
                     r_sh_kind <= KIND_GLAT;
                     r_state   <= ST_GLAT;
                  end
               end
            end
            ST_GLAT: begin
               if (w_xfer) begin
                  r_sh_valid   <= 1'b0;
                  r_frame_done <= 1'b1;
                  r_state      <= ST_DONE;
               end
            end
            ST_DONE: begin
               r_frame_done <= 1'b0;
               r_busy       <= 1'b0;
               r_state      <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign fb_rd_en   = r_fb_rd_en;
   assign sh_valid   = r_sh_valid;
   assign sh_data    = r_sh_data;
   assign sh_kind    = r_sh_kind;
   assign busy       = r_busy;
   assign frame_done = r_frame_done;

endmodule

// File: tb/tb_my9262_frame_sched.sv
// Scoreboard bench for my9262_frame_sched: a 2-chip and a 1-chip instance,
// expected words/addresses queued at stimulus time, checked by monitors.
`timescale 1ns/1ps

module tb_my9262_frame_sched;

   typedef struct packed {
      logic [15:0] d;
      logic [1:0]  k;
   } item_t;

   logic CLK_200M = 1'b0;
   logic RST_N    = 1'b0;
   always #5 CLK_200M = ~CLK_200M;

   logic        frame_start_a = 0, cfg_req_a = 0, sh_ready_a = 1;
   logic [15:0] cfg_word_a = 16'h1234;
   logic        fb_rd_en_a, sh_valid_a, busy_a, frame_done_a;
   logic [9:0]  fb_rd_addr_a;
   logic [15:0] fb_rd_data_a = '0, sh_data_a;
   logic [1:0]  sh_kind_a;

   logic        frame_start_b = 0, cfg_req_b = 0, sh_ready_b = 1;
   logic [15:0] cfg_word_b = 16'h0F0F;
   logic        fb_rd_en_b, sh_valid_b, busy_b, frame_done_b;
   logic [9:0]  fb_rd_addr_b;
   logic [15:0] fb_rd_data_b = '0, sh_data_b;
   logic [1:0]  sh_kind_b;

   my9262_frame_sched #(.NUM_CHIPS(2), .CH_PER_CHIP(16), .ADDR_W(10)) dut_a (
      .CLK_200M(CLK_200M), .RST_N(RST_N),
      .frame_start(frame_start_a), .cfg_req(cfg_req_a), .cfg_word(cfg_word_a),
      .fb_rd_en(fb_rd_en_a), .fb_rd_addr(fb_rd_addr_a), .fb_rd_data(fb_rd_data_a),
      .sh_valid(sh_valid_a), .sh_ready(sh_ready_a), .sh_data(sh_data_a),
      .sh_kind(sh_kind_a), .busy(busy_a), .frame_done(frame_done_a));

   my9262_frame_sched #(.NUM_CHIPS(1), .CH_PER_CHIP(16), .ADDR_W(10)) dut_b (
      .CLK_200M(CLK_200M), .RST_N(RST_N),
      .frame_start(frame_start_b), .cfg_req(cfg_req_b), .cfg_word(cfg_word_b),
      .fb_rd_en(fb_rd_en_b), .fb_rd_addr(fb_rd_addr_b), .fb_rd_data(fb_rd_data_b),
      .sh_valid(sh_valid_b), .sh_ready(sh_ready_b), .sh_data(sh_data_b),
      .sh_kind(sh_kind_b), .busy(busy_b), .frame_done(frame_done_b));

   // frame buffer: word at address a holds 16'hC000 | a, 1-cycle latency
   always @(posedge CLK_200M) begin
      if (fb_rd_en_a) fb_rd_data_a <= 16'hC000 | {6'b0, fb_rd_addr_a};
      if (fb_rd_en_b) fb_rd_data_b <= 16'hC000 | {6'b0, fb_rd_addr_b};
   end

   int nvec = 0;
   int nerr = 0;

   item_t      sh_qa[$], sh_qb[$];
   logic [9:0] ad_qa[$], ad_qb[$];
   int         dn_qa[$], dn_qb[$];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h, required %h", nm, act, exp);
      end
   endtask

   task automatic unexp(input string nm, input logic [31:0] act);
      nvec++;
      nerr++;
      $display("FAIL %s: unexpected output %h, none required", nm, act);
   endtask

   task automatic qpush(input bit b, input item_t it);
      if (b) sh_qb.push_back(it);
      else   sh_qa.push_back(it);
   endtask

   task automatic push_frame(input bit b, input bit cfg, input logic [15:0] cw);
      int nc;
      int n;
      item_t it;
      logic [15:0] a;
      nc = b ? 1 : 2;
      n  = 0;
      if (cfg) begin
         for (int c = nc - 1; c >= 0; c--) begin
            it.d = cw;
            it.k = (c == 0) ? 2'd3 : 2'd0;
            qpush(b, it);
            n++;
         end
      end
      for (int ch = 0; ch < 16; ch++) begin
         for (int c = nc - 1; c >= 0; c--) begin
            a    = 16'(ch * nc + c);
            it.d = 16'hC000 | a;
            it.k = (c == 0) ? 2'd1 : 2'd0;
            qpush(b, it);
            if (b) ad_qb.push_back(a[9:0]);
            else   ad_qa.push_back(a[9:0]);
            n++;
         end
      end
      it.d = 16'h0000;
      it.k = 2'd2;
      qpush(b, it);
      n++;
      if (b) dn_qb.push_back(n);
      else   dn_qa.push_back(n);
   endtask

   task automatic pulse_start(input bit b);
      @(posedge CLK_200M);
      #1;
      if (b) frame_start_b = 1; else frame_start_a = 1;
      @(posedge CLK_200M);
      #1;
      if (b) frame_start_b = 0; else frame_start_a = 0;
   endtask

   task automatic wait_done(input bit b, input int budget);
      bit seen;
      seen = 0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge CLK_200M);
         seen = b ? frame_done_b : frame_done_a;
      end
      if (!seen) begin
         nvec++;
         nerr++;
         $display("FAIL done_timeout: no frame_done within %0d cycles", budget);
      end
   endtask

   // monitor A: addresses, words, stall stability, words per frame
   bit          hold_a = 0;
   logic [15:0] hd_a;
   logic [1:0]  hk_a;
   int          xfer_a = 0;
   item_t       it_a;

   always @(negedge CLK_200M) begin
      if (!RST_N) begin
         hold_a = 0;
         xfer_a = 0;
      end else begin
         if (fb_rd_en_a) begin
            if (ad_qa.size() == 0) unexp("addr_a", 32'(fb_rd_addr_a));
            else chk("addr_a", 32'(fb_rd_addr_a), 32'(ad_qa.pop_front()));
         end
         if (sh_valid_a) begin
            if (hold_a) begin
               chk("hold_data_a", 32'(sh_data_a), 32'(hd_a));
               chk("hold_kind_a", 32'(sh_kind_a), 32'(hk_a));
            end
            if (sh_ready_a) begin
               xfer_a++;
               hold_a = 0;
               if (sh_qa.size() == 0) unexp("word_a", 32'(sh_data_a));
               else begin
                  it_a = sh_qa.pop_front();
                  chk("data_a", 32'(sh_data_a), 32'(it_a.d));
                  chk("kind_a", 32'(sh_kind_a), 32'(it_a.k));
               end
            end else begin
               hold_a = 1;
               hd_a   = sh_data_a;
               hk_a   = sh_kind_a;
            end
         end else begin
            if (hold_a) chk("hold_valid_a", 32'(sh_valid_a), 32'd1);
            hold_a = 0;
         end
         if (frame_done_a) begin
            if (dn_qa.size() == 0) unexp("done_a", 32'(xfer_a));
            else chk("words_per_frame_a", 32'(xfer_a), 32'(dn_qa.pop_front()));
            xfer_a = 0;
         end
      end
   end

   // monitor B: single-chip chain
   int    xfer_b = 0;
   item_t it_b;

   always @(negedge CLK_200M) begin
      if (!RST_N) begin
         xfer_b = 0;
      end else begin
         if (fb_rd_en_b) begin
            if (ad_qb.size() == 0) unexp("addr_b", 32'(fb_rd_addr_b));
            else chk("addr_b", 32'(fb_rd_addr_b), 32'(ad_qb.pop_front()));
         end
         if (sh_valid_b && sh_ready_b) begin
            xfer_b++;
            if (sh_qb.size() == 0) unexp("word_b", 32'(sh_data_b));
            else begin
               it_b = sh_qb.pop_front();
               chk("data_b", 32'(sh_data_b), 32'(it_b.d));
               chk("kind_b", 32'(sh_kind_b), 32'(it_b.k));
            end
         end
         if (frame_done_b) begin
            if (dn_qb.size() == 0) unexp("done_b", 32'(xfer_b));
            else chk("words_per_frame_b", 32'(xfer_b), 32'(dn_qb.pop_front()));
            xfer_b = 0;
         end
      end
   end

   task automatic chk_zero_a(input string tag);
      chk({tag, "_valid"}, 32'(sh_valid_a), 0);
      chk({tag, "_data"},  32'(sh_data_a), 0);
      chk({tag, "_kind"},  32'(sh_kind_a), 0);
      chk({tag, "_busy"},  32'(busy_a), 0);
      chk({tag, "_done"},  32'(frame_done_a), 0);
      chk({tag, "_rden"},  32'(fb_rd_en_a), 0);
      chk({tag, "_addr"},  32'(fb_rd_addr_a), 0);
   endtask

   initial begin
      // reset state
      repeat (3) @(posedge CLK_200M);
      #1;
      chk_zero_a("rst");
      chk("rst_valid_b", 32'(sh_valid_b), 0);
      chk("rst_busy_b", 32'(busy_b), 0);
      RST_N = 1;
      repeat (2) @(posedge CLK_200M);

      // frame 1: first frame always configures
      push_frame(0, 1, 16'h1234);
      pulse_start(0);
      chk("busy_latency", 32'(busy_a), 1);
      @(posedge CLK_200M);
      #1;
      chk("cfg_valid_latency", 32'(sh_valid_a), 1);
      wait_done(0, 300);
      @(negedge CLK_200M);
      chk("done_pulse_width", 32'(frame_done_a), 0);
      chk("busy_after_done", 32'(busy_a), 0);

      // frame 2: no config, 3-cycle latency, 5-cycle stall mid-frame
      push_frame(0, 0, 16'h0000);
      pulse_start(0);
      @(posedge CLK_200M);
      #1;
      chk("data_valid_early", 32'(sh_valid_a), 0);
      @(posedge CLK_200M);
      #1;
      chk("data_valid_latency", 32'(sh_valid_a), 1);
      for (int i = 0; i < 200 && xfer_a < 10; i++) @(posedge CLK_200M);
      #1;
      sh_ready_a = 0;
      repeat (5) @(posedge CLK_200M);
      #1;
      sh_ready_a = 1;
      wait_done(0, 300);

      // frames 3 and 4: requests during busy are kept and collapse
      push_frame(0, 0, 16'h0000);
      push_frame(0, 1, 16'hBEEF);
      pulse_start(0);
      repeat (20) @(posedge CLK_200M);
      #1;
      cfg_word_a    = 16'hBEEF;
      frame_start_a = 1;
      cfg_req_a     = 1;
      @(posedge CLK_200M);
      #1;
      frame_start_a = 0;
      cfg_req_a     = 0;
      repeat (10) @(posedge CLK_200M);
      pulse_start(0);
      wait_done(0, 300);
      wait_done(0, 300);
      repeat (10) @(posedge CLK_200M);
      #1;
      chk("no_extra_frame", 32'(busy_a), 0);

      // frame 5 aborted by reset during SEND
      push_frame(0, 0, 16'h0000);
      pulse_start(0);
      for (int i = 0; i < 50 && !sh_valid_a; i++) @(negedge CLK_200M);
      #2;
      RST_N = 0;
      #1;
      chk_zero_a("async_rst");
      sh_qa.delete();
      ad_qa.delete();
      dn_qa.delete();
      repeat (2) @(posedge CLK_200M);
      #1;
      RST_N = 1;

      // frame 6: config is resent after reset
      push_frame(0, 1, 16'hBEEF);
      pulse_start(0);
      wait_done(0, 300);

      // single-chip chain
      push_frame(1, 1, 16'h0F0F);
      pulse_start(1);
      wait_done(1, 300);

      repeat (5) @(posedge CLK_200M);
      chk("words_left_a", 32'(sh_qa.size()), 0);
      chk("addrs_left_a", 32'(ad_qa.size()), 0);
      chk("frames_left_a", 32'(dn_qa.size()), 0);
      chk("words_left_b", 32'(sh_qb.size()), 0);
      chk("addrs_left_b", 32'(ad_qb.size()), 0);
      chk("frames_left_b", 32'(dn_qb.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
